ps2_key_matrix: RTL
===================

Name: ps2_key_matrix

Overview:
Parametrised PS/2-to-key-matrix converter between hps_io ps2_key and any console with a strobed keyboard matrix. Scancode-to-position mapping is held in a loadable table, not hard-coded. Key state is held in a ROWS x COLS register array and merged with an external overlay such as joystick bits. Also provides a key-held counter and a timed clear-all sweep.

Parameters:
ROWS, 8, number of matrix strobe lines (power of 2, 2..16)
COLS, 8, number of matrix return lines (power of 2, 2..16)
RB, $clog2(ROWS), row index width (derived)
CB, $clog2(COLS), column index width (derived)
NW, $clog2(ROWS*COLS+1), key_count width (derived)

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
map_we  in  1  mapping-table write strobe
map_addr  in  9  {extended, scancode} entry to write
map_data  in  1+RB+CB  {valid, row, col}
row_sel_n  in  ROWS  active-low row strobes from console
ovl_keys  in  ROWS*COLS  active-high overlay; bit r*COLS+c ORs into key (r,c)
clear_all  in  1  single-cycle request to release all keys
col_n  out  COLS  active-low key returns to console
key_count  out  NW  number of matrix keys currently held (overlay excluded)
busy  out  1  high while clear sweep runs

Behaviour:
- Reset values:
  - col_n all 1; key_count 0; busy 0.
  - key state all 0; FSM IDLE; primed 0; pipeline valid bits 0.
  - Mapping table (512 x (1+RB+CB) RAM) is not reset.
- Event detect:
  - toggle_q registers ps2_key[10] every cycle.
  - First cycle after reset: primed is set and no event is raised.
  - Afterwards, event when ps2_key[10] != toggle_q.
  - pressed and the 9-bit address are captured with the event.
- Pipeline, with edge E being the edge where the toggle change is sampled:
  - E+1: address presented to table.
  - E+2: synchronous read data valid; key state updated at this edge.
  - E+3: col_n reflects the change.
  - key_count updates at E+2.
  - Back-to-back events on consecutive cycles are all applied in order.
- Entry with valid=0: event ignored; state and count unchanged.
- Press of an already-held key, or release of a non-held key: no change; count unchanged.
- key_count:
  - +1 on a 0->1 transition, -1 on a 1->0 transition.
  - Cannot exceed ROWS*COLS or go below 0 by construction.
- Table write:
  - map_we writes at the clock edge.
  - A lookup of the same address in the same cycle returns the old data (read-before-write).
- col_n:
  - Registered.
  - col_n[c] = ~OR over r of (~row_sel_n[r] & (state[r][c] | ovl_keys[r*COLS+c])).
  - Multiple rows strobed: wired-AND behaviour, i.e. OR of all selected rows.
  - No rows strobed: all 1.
- FSM:
  - IDLE: on clear_all, go to CLEAR with row index 0 and busy=1.
  - CLEAR: each cycle zero one row, index+1; after row ROWS-1 (ROWS cycles total), set key_count=0, busy=0, return to IDLE.
  - clear_all while busy: ignored.
  - PS/2 events sampled during CLEAR are discarded, but toggle_q keeps tracking so no spurious event follows.
  - Events already in the pipeline when CLEAR starts may update rows not yet cleared; they are cleared by the sweep. key_count is forced to 0 at completion regardless.
- Reset asserted mid-sweep or mid-pipeline: immediate return to reset values.

Test Plan:
- Load map 0x01C -> {1,r5,c0}; toggle ps2_key with pressed=1, code 0x1C; row_sel_n=8'hDF -> col_n=8'hFE exactly 3 edges after the change; key_count=1. Release -> col_n=8'hFF, key_count=0.
- Two presses of the same key, then one release -> key_count goes 1,1,0. Event at an unmapped address (valid=0) -> no change.
- Extended 0x175 mapped to r4,c1 and 0x075 unmapped -> only an extended-flag event asserts col_n[1] with row 4 strobed.
- Hold 3 keys, pulse clear_all -> busy high for exactly 8 cycles, all state 0, key_count 0. A PS/2 press mid-sweep -> not applied, and no event afterwards. A second clear_all while busy is ignored.
- ovl_keys bit 0 set, state 0, row_sel_n=8'hFE -> col_n=8'hFE. key_count stays 0.
- Assert reset mid-sweep with keys held -> col_n=8'hFF, busy 0, key_count 0 asynchronously. First cycle after release produces no event even if toggle differs.

Source files
------------

// File: rtl/ps2_key_matrix.sv
// PS/2-to-key-matrix converter.
// Turns hps_io ps2_key events into a ROWS x COLS key-state array that a console
// scans with active-low row strobes. A loadable 512-entry table maps each
// {extended, scancode} to {valid, row, col}. The key state is ORed with an
// external overlay (e.g. joystick bits) before it drives the column returns.
// A clear_all pulse starts a sweep that releases every key, one row per cycle.
//
// Ports:
//   clk_sys_i    system clock
//   reset_i      asynchronous active-high reset
//   ps2_key_i    [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   map_we_i     mapping-table write strobe
//   map_addr_i   {extended, scancode} entry to write
//   map_data_i   {valid, row, col}
//   row_sel_n_i  active-low row strobes from the console
//   ovl_keys_i   active-high overlay, bit r*COLS+c ORs into key (r,c)
//   clear_all_i  single-cycle request to release all keys
//   col_n_o      registered active-low key returns
//   key_count_o  number of matrix keys held (overlay excluded)
//   busy_o       high while the clear sweep runs
module ps2_key_matrix #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned RB   = $clog2(ROWS),
  parameter int unsigned CB   = $clog2(COLS),
  parameter int unsigned NW   = $clog2(ROWS * COLS + 1)
) (
  input  logic                   clk_sys_i,
  input  logic                   reset_i,
  input  logic [10:0]            ps2_key_i,
  input  logic                   map_we_i,
  input  logic [8:0]             map_addr_i,
  input  logic [RB+CB:0]         map_data_i,
  input  logic [ROWS-1:0]        row_sel_n_i,
  input  logic [ROWS*COLS-1:0]   ovl_keys_i,
  input  logic                   clear_all_i,
  output logic [COLS-1:0]        col_n_o,
  output logic [NW-1:0]          key_count_o,
  output logic                   busy_o
);

  localparam int unsigned W = 1 + RB + CB;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [RB-1:0]   row_idx_q, row_idx_d;
  logic            sweep_last;

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      row_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    case (state_q)
      StIdle: begin
        if (clear_all_i) begin
          state_d   = StClear;
          row_idx_d = '0;
        end
      end
      StClear: begin
        row_idx_d = row_idx_q + RB'(1);
        if (row_idx_q == '1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == StClear);
    sweep_last = busy_o && (row_idx_q == '1);
  end

  // ---------------------------------------------------------------------------
  // Event detect and pipeline
  // ---------------------------------------------------------------------------
  logic       toggle_q, primed_q, ev;
  logic       s1_vld_q, s1_pressed_q, s2_vld_q, s2_pressed_q;
  logic [8:0] s1_addr_q;

  // primed_q masks the first cycle after reset, when toggle_q is not yet valid.
  // Events seen during the sweep are dropped while toggle_q keeps tracking.
  always_comb ev = primed_q && (ps2_key_i[10] != toggle_q) && (state_q != StClear);

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      toggle_q     <= 1'b0;
      primed_q     <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_pressed_q <= 1'b0;
      s1_addr_q    <= '0;
      s2_vld_q     <= 1'b0;
      s2_pressed_q <= 1'b0;
    end else begin
      toggle_q     <= ps2_key_i[10];
      primed_q     <= 1'b1;
      s1_vld_q     <= ev;
      if (ev) begin
        s1_pressed_q <= ps2_key_i[9];
        s1_addr_q    <= ps2_key_i[8:0];
      end
      s2_vld_q     <= s1_vld_q;
      s2_pressed_q <= s1_pressed_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Mapping table: synchronous read, read-before-write on address collision
  // ---------------------------------------------------------------------------
  logic [W-1:0] map_mem [0:511];
  logic [W-1:0] rd_q;

  always_ff @(posedge clk_sys_i) begin
    if (map_we_i) map_mem[map_addr_i] <= map_data_i;
    rd_q <= map_mem[s1_addr_q];
  end

  // ---------------------------------------------------------------------------
  // Key state and held counter
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0][COLS-1:0] key_q, key_d;
  logic [NW-1:0]             cnt_q, cnt_d;
  logic                      hit_vld, hit_cur;
  logic [RB-1:0]             hit_row;
  logic [CB-1:0]             hit_col;

  always_comb begin
    hit_row = rd_q[CB +: RB];
    hit_col = rd_q[0 +: CB];
    hit_cur = key_q[hit_row][hit_col];
    // Updates landing during the sweep are dropped; the sweep result is all-clear.
    hit_vld = s2_vld_q && rd_q[W-1] && !busy_o;
    key_d   = key_q;
    cnt_d   = cnt_q;
    // Only a real 0->1 or 1->0 change touches the count.
    if (hit_vld && (s2_pressed_q != hit_cur)) begin
      key_d[hit_row][hit_col] = s2_pressed_q;
      cnt_d = s2_pressed_q ? cnt_q + NW'(1) : cnt_q - NW'(1);
    end
    if (busy_o) begin
      key_d[row_idx_q] = '0;
      if (sweep_last) cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Column returns: OR of every strobed row, active low
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0][COLS-1:0] eff;
  logic [COLS-1:0]           col_act;
  logic [COLS-1:0]           col_n_q, col_n_d;

  always_comb begin
    eff     = key_q | ovl_keys_i;
    col_act = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_sel_n_i[r]) col_act = col_act | eff[r];
    end
    col_n_d = ~col_act;
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      key_q   <= '0;
      cnt_q   <= '0;
      col_n_q <= '1;
    end else begin
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      col_n_q <= col_n_d;
    end
  end

  assign col_n_o     = col_n_q;
  assign key_count_o = cnt_q;

endmodule
